// File: rtl/mesi_snoop_bus.sv
`default_nettype none
// ============================================================================
// Module      : mesi_snoop_bus
// Description : Shared snooping-bus controller for MESI caches.
//               Round-robin arbitration of read/write miss requests from
//               N_CACHES caches, a single-cycle BR/BW snoop broadcast to all
//               non-owner caches, a MEM_LAT-cycle memory phase and a
//               one-cycle response carrying done and the S (shared) flag.
//               Sequence per transaction: IDLE -> SNOOP -> MEM -> RESP.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   N_CACHES  number of caches on the bus (>=2)
//   MEM_LAT   memory access cycles per transaction (>=1)
// Ports:
//   clk      in   1         rising-edge clock
//   reset    in   1         asynchronous, active-low reset
//   req_rd   in   N_CACHES  read-miss request per cache, held until done
//   req_wr   in   N_CACHES  write-miss/upgrade request per cache, held until done
//   grant    out  N_CACHES  one-hot owner of the current transaction
//   done     out  N_CACHES  one-cycle completion pulse to the owner
//   shared   out  1         valid with done: another cache holds the line
//   snp_br   out  N_CACHES  bus-read snoop to every non-owner cache
//   snp_bw   out  N_CACHES  bus-write snoop to every non-owner cache
//   snp_hit  in   N_CACHES  combinational snoop response (cache holds line)
//   busy     out  1         high whenever the bus is not idle
// Optional build macro:
//   MESI_BUS_STATS_EN  adds rd_cnt[15:0] / wr_cnt[15:0], saturating counts
//                      of completed read and write transactions.
// ============================================================================
module mesi_snoop_bus #(
  parameter int N_CACHES = 4,
  parameter int MEM_LAT  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CACHES-1:0] req_rd,
  input  logic [N_CACHES-1:0] req_wr,
  output logic [N_CACHES-1:0] grant,
  output logic [N_CACHES-1:0] done,
  output logic                shared,
  output logic [N_CACHES-1:0] snp_br,
  output logic [N_CACHES-1:0] snp_bw,
  input  logic [N_CACHES-1:0] snp_hit,
  output logic                busy
`ifdef MESI_BUS_STATS_EN
  ,
  output logic [15:0]         rd_cnt,
  output logic [15:0]         wr_cnt
`endif
);

  localparam int OW = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;
  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_MEM   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t               state;
  logic [OW-1:0]        rr_ptr;
  logic [OW-1:0]        owner;
  logic                 op_wr;
  logic                 hit_q;
  logic [CW-1:0]        cnt;

  logic [N_CACHES-1:0]  req_any;
  logic [N_CACHES-1:0]  owner_oh;
  logic                 hit_w;
  logic                 pick_valid;
  logic [OW-1:0]        pick_idx;
  logic [OW:0]          cand_sum;
  logic [OW-1:0]        cand_idx;

  function automatic logic [N_CACHES-1:0] onehot(input logic [OW-1:0] idx);
    logic [N_CACHES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign req_any  = req_rd | req_wr;
  assign owner_oh = onehot(owner);

  // The owner may legitimately report a hit for its own line (e.g. an
  // upgrade from S); only other caches decide the shared indication.
  assign hit_w = |(snp_hit & ~owner_oh);

  // Round-robin pick: scan from rr_ptr upward, wrapping modulo N_CACHES.
  // cand_sum is one bit wider so rr_ptr+i never overflows before the wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand_idx   = '0;
    for (int i = 0; i < N_CACHES; i++) begin
      cand_sum = {1'b0, rr_ptr} + (OW+1)'(i);
      if (cand_sum >= (OW+1)'(N_CACHES)) begin
        cand_sum = cand_sum - (OW+1)'(N_CACHES);
      end
      cand_idx = cand_sum[OW-1:0];
      if (!pick_valid && req_any[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Bus FSM with registered outputs: each output is set on the edge that
  // enters the state in which it must be visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      op_wr  <= 1'b0;
      hit_q  <= 1'b0;
      cnt    <= '0;
      grant  <= '0;
      done   <= '0;
      shared <= 1'b0;
      snp_br <= '0;
      snp_bw <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner <= pick_idx;
            // A cache raising both request lines is treated as a writer.
            op_wr <= req_wr[pick_idx];
            grant <= onehot(pick_idx);
            busy  <= 1'b1;
            if (req_wr[pick_idx]) begin
              snp_bw <= ~onehot(pick_idx);
            end else begin
              snp_br <= ~onehot(pick_idx);
            end
            state <= ST_SNOOP;
          end
        end

        ST_SNOOP: begin
          hit_q  <= hit_w;
          snp_br <= '0;
          snp_bw <= '0;
          cnt    <= CW'(MEM_LAT - 1);
          state  <= ST_MEM;
        end

        ST_MEM: begin
          if (cnt == '0) begin
            done   <= owner_oh;
            shared <= hit_q & ~op_wr;
            state  <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_RESP: begin
          done   <= '0;
          shared <= 1'b0;
          grant  <= '0;
          busy   <= 1'b0;
          rr_ptr <= (owner == OW'(N_CACHES - 1)) ? '0 : owner + 1'b1;
          state  <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MESI_BUS_STATS_EN
  // Completed-transaction counters; they advance on the RESP cycle and
  // hold at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state == ST_RESP) begin
      if (op_wr) begin
        if (wr_cnt != 16'hFFFF) begin
          wr_cnt <= wr_cnt + 16'd1;
        end
      end else begin
        if (rd_cnt != 16'hFFFF) begin
          rd_cnt <= rd_cnt + 16'd1;
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mesi_snoop_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesi_snoop_bus
// Description : Self-checking bench for mesi_snoop_bus (N_CACHES=4,
//               MEM_LAT=3). A transaction-timeline model predicts every
//               output each cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesi_snoop_bus;

  localparam int N = 4;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_rd;
  logic [N-1:0] req_wr;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic         shared;
  logic [N-1:0] snp_br;
  logic [N-1:0] snp_bw;
  logic [N-1:0] snp_hit;
  logic         busy;
`ifdef MESI_BUS_STATS_EN
  logic [15:0]  rd_cnt;
  logic [15:0]  wr_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: a transaction is an owner plus a cycle offset k (1..L+2).
  bit m_active = 0;
  int m_owner  = 0;
  bit m_write  = 0;
  int m_k      = 0;
  bit m_hit    = 0;
  int m_ptr    = 0;

  mesi_snoop_bus #(.N_CACHES(N), .MEM_LAT(L)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_rd  (req_rd),
    .req_wr  (req_wr),
    .grant   (grant),
    .done    (done),
    .shared  (shared),
    .snp_br  (snp_br),
    .snp_bw  (snp_bw),
    .snp_hit (snp_hit),
    .busy    (busy)
`ifdef MESI_BUS_STATS_EN
    ,
    .rd_cnt  (rd_cnt),
    .wr_cnt  (wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model for this cycle, then advance the model.
  task automatic model_step();
    logic [N-1:0] oh;
    logic [N-1:0] e_grant, e_done, e_br, e_bw, reqs;
    logic         e_shared, e_busy;
    if (!reset) begin
      m_active = 0;
      m_ptr    = 0;
      m_k      = 0;
    end
    oh       = 4'b0001 << m_owner;
    e_grant  = '0;
    e_done   = '0;
    e_br     = '0;
    e_bw     = '0;
    e_shared = 1'b0;
    e_busy   = 1'b0;
    if (m_active) begin
      e_grant = oh;
      e_busy  = 1'b1;
      if (m_k == 1) begin
        if (m_write) e_bw = ~oh;
        else         e_br = ~oh;
      end
      if (m_k == L + 2) begin
        e_done   = oh;
        e_shared = !m_write && m_hit;
      end
    end
    chk("m_grant",  32'(grant),  32'(e_grant));
    chk("m_done",   32'(done),   32'(e_done));
    chk("m_shared", 32'(shared), 32'(e_shared));
    chk("m_snp_br", 32'(snp_br), 32'(e_br));
    chk("m_snp_bw", 32'(snp_bw), 32'(e_bw));
    chk("m_busy",   32'(busy),   32'(e_busy));
    if (!reset) return;
    if (m_active) begin
      if (m_k == 1) m_hit = |(snp_hit & ~oh);
      if (m_k == L + 2) begin
        m_active = 0;
        m_ptr    = (m_owner + 1) % N;
      end else begin
        m_k++;
      end
    end else begin
      reqs = req_rd | req_wr;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (!m_active && reqs[c]) begin
          m_active = 1;
          m_owner  = c;
          m_write  = req_wr[c];
          m_k      = 1;
        end
      end
    end
  endtask

  // One clock: model check at the falling edge, then requesters that just
  // received done release their request lines shortly after the rising edge.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    req_rd = req_rd & ~done;
    req_wr = req_wr & ~done;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      if (!busy && ((req_rd | req_wr) == '0)) break;
      tick();
    end
    chk("drain_timeout", 32'(busy | (|(req_rd | req_wr))), 32'd0);
  endtask

  // Single transaction from IDLE with literal expectations at t1, t2, t4, t5, t6.
  task automatic run_one(input string nm, input logic [N-1:0] rd, input logic [N-1:0] wr,
                         input logic [N-1:0] hit, input logic [N-1:0] exp_g,
                         input logic [N-1:0] exp_br, input logic [N-1:0] exp_bw,
                         input logic exp_sh);
    req_rd  = rd;
    req_wr  = wr;
    snp_hit = hit;
    tick();
    chk({nm, "_t1_grant"},  32'(grant),  32'(exp_g));
    chk({nm, "_t1_snp_br"}, 32'(snp_br), 32'(exp_br));
    chk({nm, "_t1_snp_bw"}, 32'(snp_bw), 32'(exp_bw));
    chk({nm, "_t1_busy"},   32'(busy),   32'd1);
    tick();
    chk({nm, "_t2_snoop_off"}, 32'(snp_br | snp_bw), 32'd0);
    chk({nm, "_t2_grant"},     32'(grant),           32'(exp_g));
    repeat (L - 1) tick();
    chk({nm, "_t4_no_done"}, 32'(done), 32'd0);
    tick();
    chk({nm, "_t5_done"},   32'(done),   32'(exp_g));
    chk({nm, "_t5_shared"}, 32'(shared), 32'(exp_sh));
    snp_hit = '0;
    tick();
    chk({nm, "_t6_idle"}, 32'(busy | (|done)), 32'd0);
  endtask

  initial begin
    int order[$];
    int exp_order[6];
    logic [N-1:0] prev;

    reset   = 1'b0;
    req_rd  = '0;
    req_wr  = '0;
    snp_hit = '0;
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_snoop", 32'(snp_br | snp_bw), 32'd0);
    reset = 1'b1;
    tick();

    // Reads and writes with different snoop responses.
    run_one("rd1_nohit",  4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b1101, 4'b0000, 1'b0);
    run_one("rd1_hit2",   4'b0010, 4'b0000, 4'b0100, 4'b0010, 4'b1101, 4'b0000, 1'b1);
    run_one("rd1_selfhit",4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b1101, 4'b0000, 1'b0);
    run_one("wr2_hit0",   4'b0000, 4'b0100, 4'b0001, 4'b0100, 4'b0000, 4'b1011, 1'b0);
    run_one("rdwr3",      4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0111, 1'b0);
`ifdef MESI_BUS_STATS_EN
    chk("stats_rd", 32'(rd_cnt), 32'd3);
    chk("stats_wr", 32'(wr_cnt), 32'd2);
`endif

    // Round-robin ordering with re-requests arriving while busy.
    exp_order = '{0, 1, 3, 0, 1, 3};
    prev      = '0;
    req_rd    = 4'b1011;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (grant != '0 && prev == '0) begin
        for (int j = 0; j < N; j++) begin
          if (grant[j]) order.push_back(j);
        end
        if (order.size() == 2) req_rd[0] = 1'b1;
        if (order.size() == 4) begin
          req_rd[1] = 1'b1;
          req_rd[3] = 1'b1;
        end
      end
      prev = grant;
      if (order.size() == 6 && !busy && ((req_rd | req_wr) == '0)) break;
    end
    chk("order_len", 32'(order.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < order.size()) chk($sformatf("order_%0d", k), 32'(order[k]), 32'(exp_order[k]));
    end

    // Asynchronous reset in the middle of MEM.
    req_rd = 4'b1000;
    tick();
    chk("abort_grant3", 32'(grant), 32'(4'b1000));
    tick();
    req_rd[0] = 1'b1;
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_done",  32'(done | {3'b0, shared}), 32'd0);
    chk("abort_snoop", 32'(snp_br | snp_bw), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("restart_grant0", 32'(grant),  32'(4'b0001));
    chk("restart_snp_br", 32'(snp_br), 32'(4'b1110));
    wait_idle(100);

`ifdef MESI_BUS_STATS_EN
    force dut.rd_cnt = 16'hFFFF;
    force dut.wr_cnt = 16'hFFFF;
    tick();
    release dut.rd_cnt;
    release dut.wr_cnt;
    run_one("sat_rd", 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b1101, 4'b0000, 1'b0);
    run_one("sat_wr", 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b1011, 1'b0);
    chk("sat_rd_cnt", 32'(rd_cnt), 32'h0000FFFF);
    chk("sat_wr_cnt", 32'(wr_cnt), 32'h0000FFFF);
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
